cam_partition_reconfig_ctrl: RTL and testbench

Sequencer that resizes a partitioned CAM (e.g. the issue-queue wakeup CAM) at runtime by power-gating or re-enabling whole partitions. On a reconfiguration request it stalls allocation, waits for the structure to drain, then either gates the upper partitions or ungates them, waits for them to settle, and scrubs every newly enabled entry through a dedicated write port. It drives the CAM's `partitionGated_i` and one write port, and reports the active partition count to allocation logic.

---
 rtl/cam_partition_reconfig_ctrl.sv | 144 ++++++++++++++
 tb/tb_cam_partition_reconfig_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_partition_reconfig_ctrl.sv
// Runtime resize sequencer for a partitioned CAM: drains, gates or ungates the
// upper partitions, waits for them to settle and scrubs newly enabled entries.
module cam_partition_reconfig_ctrl #(
  parameter int unsigned      DEPTH         = 64,
  parameter int unsigned      INDEX         = 6,
  parameter int unsigned      WIDTH         = 7,
  parameter int unsigned      NUM_PARTS     = 4,
  parameter int unsigned      NUM_PARTS_LOG = 2,
  parameter int unsigned      WAKE_DELAY    = 4,
  parameter logic [WIDTH-1:0] CLEAR_VAL     = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reconfigReq_i,
  input  logic [NUM_PARTS_LOG:0] activeParts_i,
  input  logic                   pipeEmpty_i,
  output logic [NUM_PARTS-1:0]   partitionGated_o,
  output logic                   clrWrEn_o,
  output logic [INDEX-1:0]       clrAddr_o,
  output logic [WIDTH-1:0]       clrData_o,
  output logic                   stallAlloc_o,
  output logic                   busy_o,
  output logic [NUM_PARTS_LOG:0] activeParts_o,
  output logic                   reconfigDone_o,
  output logic                   cfgErr_o
);

  localparam int unsigned CW        = NUM_PARTS_LOG + 1;
  localparam int unsigned AW        = INDEX + 1;
  localparam int unsigned PART_SIZE = DEPTH / NUM_PARTS;
  localparam int unsigned CNT_W     = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_GATE, S_WAKE, S_CLEAR, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_target, w_target;
  logic [CW-1:0]        r_active, w_active;
  logic [NUM_PARTS-1:0] r_gated, w_gated;
  logic [AW-1:0]        r_addr, w_addr;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic                 r_err, w_err;
  logic [AW-1:0]        w_startAddr, w_lastAddr;

  // Bit p set for every partition below n.
  function automatic logic [NUM_PARTS-1:0] low_mask(input logic [CW-1:0] n);
    low_mask = '0;
    for (int p = 0; p < NUM_PARTS; p++) low_mask[p] = (p < int'(n));
  endfunction

  // Extra address bit keeps the end-of-CAM bound DEPTH from aliasing to 0.
  assign w_startAddr = AW'(r_active) * AW'(PART_SIZE);
  assign w_lastAddr  = AW'(r_target) * AW'(PART_SIZE) - AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_target <= CW'(NUM_PARTS);
      r_active <= CW'(NUM_PARTS);
      r_gated  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_target <= w_target;
      r_active <= w_active;
      r_gated  <= w_gated;
      r_addr   <= w_addr;
      r_cnt    <= w_cnt;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_target = r_target;
    w_active = r_active;
    w_gated  = r_gated;
    w_addr   = r_addr;
    w_cnt    = r_cnt;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reconfigReq_i) begin
          if (activeParts_i == '0 || activeParts_i > CW'(NUM_PARTS)) begin
            w_err = 1'b1;
          end else if (activeParts_i == r_active) begin
            w_next = S_DONE;
          end else begin
            w_target = activeParts_i;
            w_next   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pipeEmpty_i) begin
          if (r_target < r_active) begin
            w_next = S_GATE;
          end else begin
            // Ungate partitions current..target-1 as WAKE is entered.
            w_gated = r_gated & ~(low_mask(r_target) & ~low_mask(r_active));
            w_cnt   = CNT_W'(WAKE_DELAY - 1);
            w_next  = S_WAKE;
          end
        end
      end
      S_GATE: begin
        w_gated  = ~low_mask(r_target);
        w_active = r_target;
        w_next   = S_DONE;
      end
      S_WAKE: begin
        if (r_cnt == '0) begin
          w_addr = w_startAddr;
          w_next = S_CLEAR;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_CLEAR: begin
        w_addr = r_addr + AW'(1);
        if (r_addr == w_lastAddr) begin
          w_active = r_target;
          w_next   = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign partitionGated_o = r_gated;
  assign clrWrEn_o        = (r_state == S_CLEAR);
  assign clrAddr_o        = r_addr[INDEX-1:0];
  assign clrData_o        = CLEAR_VAL;
  assign stallAlloc_o     = (r_state != S_IDLE);
  assign busy_o           = (r_state != S_IDLE);
  assign activeParts_o    = r_active;
  assign reconfigDone_o   = (r_state == S_DONE);
  assign cfgErr_o         = r_err;

endmodule

// File: tb/tb_cam_partition_reconfig_ctrl.sv
// Bench for cam_partition_reconfig_ctrl: directed scenarios plus random traffic
// checked every cycle against a plan-queue model of the expected outputs.
module tb_cam_partition_reconfig_ctrl;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned INDEX      = 6;
  localparam int unsigned WIDTH      = 7;
  localparam int unsigned NP         = 4;
  localparam int unsigned NPL        = 2;
  localparam int unsigned WAKE_DELAY = 4;
  localparam int unsigned CW         = NPL + 1;
  localparam int unsigned PS         = DEPTH / NP;
  localparam logic [WIDTH-1:0] CLEAR_VAL = '0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reconfigReq_i = 1'b0;
  logic [CW-1:0] activeParts_i = CW'(NP);
  logic pipeEmpty_i = 1'b1;
  logic [NP-1:0] partitionGated_o;
  logic clrWrEn_o;
  logic [INDEX-1:0] clrAddr_o;
  logic [WIDTH-1:0] clrData_o;
  logic stallAlloc_o, busy_o, reconfigDone_o, cfgErr_o;
  logic [CW-1:0] activeParts_o;

  cam_partition_reconfig_ctrl dut (
    .clk(clk), .reset(reset), .reconfigReq_i(reconfigReq_i),
    .activeParts_i(activeParts_i), .pipeEmpty_i(pipeEmpty_i),
    .partitionGated_o(partitionGated_o), .clrWrEn_o(clrWrEn_o),
    .clrAddr_o(clrAddr_o), .clrData_o(clrData_o), .stallAlloc_o(stallAlloc_o),
    .busy_o(busy_o), .activeParts_o(activeParts_o),
    .reconfigDone_o(reconfigDone_o), .cfgErr_o(cfgErr_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one cycle
  typedef struct packed {
    logic             stall;
    logic             wr;
    logic [INDEX-1:0] addr;
    logic [NP-1:0]    gates;
    logic [CW-1:0]    act;
    logic             done;
    logic             err;
  } exp_t;

  function automatic exp_t mk(input logic s, input logic w, input int a,
                              input logic [NP-1:0] g, input logic [CW-1:0] ac,
                              input logic d, input logic e);
    exp_t r;
    r.stall = s; r.wr = w; r.addr = INDEX'(a); r.gates = g;
    r.act = ac; r.done = d; r.err = e;
    return r;
  endfunction

  exp_t          m_exp;
  exp_t          plan[$];
  logic [NP-1:0] m_gates;
  logic [CW-1:0] m_act, m_tgt;
  logic          m_drain;

  // Model: each edge decides what the outputs must show in the following cycle.
  always @(posedge clk or posedge reset) begin
    exp_t nx;
    if (reset) begin
      plan.delete();
      m_gates = '0;
      m_act   = CW'(NP);
      m_tgt   = CW'(NP);
      m_drain = 1'b0;
      m_exp   = mk(0, 0, 0, '0, CW'(NP), 0, 0);
    end else begin
      nx = mk(0, 0, 0, m_gates, m_act, 0, 0);
      if (!m_exp.stall && reconfigReq_i) begin
        if (activeParts_i == 0 || int'(activeParts_i) > NP) nx.err = 1'b1;
        else if (activeParts_i == m_act) nx = mk(1, 0, 0, m_gates, m_act, 1, 0);
        else begin
          m_tgt = activeParts_i;
          m_drain = 1'b1;
          nx.stall = 1'b1;
        end
      end else if (m_drain) begin
        nx.stall = 1'b1;
        if (pipeEmpty_i) begin
          m_drain = 1'b0;
          if (m_tgt < m_act) begin
            plan.push_back(mk(1, 0, 0, m_gates, m_act, 0, 0));
            for (int p = 0; p < NP; p++) m_gates[p] = (p >= int'(m_tgt));
            m_act = m_tgt;
            plan.push_back(mk(1, 0, 0, m_gates, m_act, 1, 0));
          end else begin
            for (int p = int'(m_act); p < int'(m_tgt); p++) m_gates[p] = 1'b0;
            repeat (WAKE_DELAY) plan.push_back(mk(1, 0, 0, m_gates, m_act, 0, 0));
            for (int a = int'(m_act) * PS; a < int'(m_tgt) * PS; a++)
              plan.push_back(mk(1, 1, a, m_gates, m_act, 0, 0));
            m_act = m_tgt;
            plan.push_back(mk(1, 0, 0, m_gates, m_act, 1, 0));
          end
          nx = plan.pop_front();
        end
      end else if (plan.size() > 0) begin
        nx = plan.pop_front();
      end
      m_exp = nx;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("stallAlloc", 32'(stallAlloc_o), 32'(m_exp.stall));
      chk("busy", 32'(busy_o), 32'(m_exp.stall));
      chk("clrWrEn", 32'(clrWrEn_o), 32'(m_exp.wr));
      if (m_exp.wr) chk("clrAddr", 32'(clrAddr_o), 32'(m_exp.addr));
      chk("clrData", 32'(clrData_o), 32'(CLEAR_VAL));
      chk("gates", 32'(partitionGated_o), 32'(m_exp.gates));
      chk("activeParts", 32'(activeParts_o), 32'(m_exp.act));
      chk("reconfigDone", 32'(reconfigDone_o), 32'(m_exp.done));
      chk("cfgErr", 32'(cfgErr_o), 32'(m_exp.err));
    end
  end

  // Grow-scenario observer: WAKE cycles and scrub writes.
  logic mon_en = 1'b0;
  int wake_cnt, wr_cnt, wr_first, wr_last;
  always @(negedge clk) begin
    if (!mon_en) begin
      wake_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1;
    end else begin
      if (stallAlloc_o && !clrWrEn_o && !reconfigDone_o &&
          partitionGated_o == '0 && activeParts_o == CW'(2)) wake_cnt++;
      if (clrWrEn_o) begin
        if (wr_cnt == 0) wr_first = int'(clrAddr_o);
        wr_last = int'(clrAddr_o);
        wr_cnt++;
      end
    end
  end

  task automatic do_req(input int tgt);
    @(negedge clk);
    reconfigReq_i = 1'b1;
    activeParts_i = CW'(tgt);
    @(negedge clk);
    reconfigReq_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (stallAlloc_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (stallAlloc_o) begin
      n_total++; n_bad++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
    @(negedge clk);
  endtask

  task automatic wait_write(input string name, input int addr);
    int n = 0;
    while (!(clrWrEn_o && (addr < 0 || int'(clrAddr_o) == addr)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(clrWrEn_o && (addr < 0 || int'(clrAddr_o) == addr))) begin
      n_total++; n_bad++;
      $display("FAIL %s: scrub write to %0d not seen", name, addr);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Shrink 4 -> 2 with pipe already empty
    do_req(2);
    wait_idle("shrink");
    chk("shrink_gates", 32'(partitionGated_o), 32'(4'b1100));
    chk("shrink_active", 32'(activeParts_o), 32'd2);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_gates", 32'(partitionGated_o), 32'd0);
    chk("rst_active", 32'(activeParts_o), 32'd4);
    chk("rst_stall", 32'(stallAlloc_o), 32'd0);
    chk("rst_addr", 32'(clrAddr_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Grow 2 -> 4 with drain held off for a few cycles
    do_req(2);
    wait_idle("shrink2");
    pipeEmpty_i = 1'b0;
    mon_en = 1'b1;
    do_req(4);
    repeat (2) @(negedge clk);
    pipeEmpty_i = 1'b1;
    wait_idle("grow");
    chk("grow_wake_cycles", 32'(wake_cnt), 32'd4);
    chk("grow_writes", 32'(wr_cnt), 32'd32);
    chk("grow_first_addr", 32'(wr_first), 32'd32);
    chk("grow_last_addr", 32'(wr_last), 32'd63);
    chk("grow_active", 32'(activeParts_o), 32'd4);
    chk("grow_gates", 32'(partitionGated_o), 32'd0);
    mon_en = 1'b0;

    // Illegal and equal targets
    do_req(0);
    chk("err_tgt0", 32'(cfgErr_o), 32'd1);
    do_req(5);
    chk("err_tgt5", 32'(cfgErr_o), 32'd1);
    @(negedge clk);
    do_req(4);
    chk("equal_done", 32'(reconfigDone_o), 32'd1);
    wait_idle("equal");

    // Request while busy is ignored
    do_req(2);
    wait_idle("shrink3");
    do_req(4);
    wait_write("busy_clear", -1);
    do_req(1);
    wait_idle("busy_grow");
    chk("busy_active", 32'(activeParts_o), 32'd4);
    chk("busy_gates", 32'(partitionGated_o), 32'd0);

    // Reset in the middle of a scrub
    do_req(2);
    wait_idle("shrink4");
    do_req(4);
    wait_write("mid_scrub", 40);
    #1 reset = 1'b1;
    #1;
    chk("mid_wr", 32'(clrWrEn_o), 32'd0);
    chk("mid_addr", 32'(clrAddr_o), 32'd0);
    chk("mid_gates", 32'(partitionGated_o), 32'd0);
    chk("mid_active", 32'(activeParts_o), 32'd4);
    chk("mid_stall", 32'(stallAlloc_o), 32'd0);
    chk("mid_done", 32'(reconfigDone_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req(1);
    wait_idle("shrink_to_1");
    chk("to1_gates", 32'(partitionGated_o), 32'(4'b1110));
    chk("to1_active", 32'(activeParts_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reconfigReq_i = ($urandom_range(0, 3) == 0);
      activeParts_i = CW'($urandom_range(0, 7));
      pipeEmpty_i   = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    reconfigReq_i = 1'b0;
    pipeEmpty_i   = 1'b1;
    wait_idle("random_tail");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
